// File: rtl/channel_avg_sequencer.sv
// ============================================================================
// Module      : channel_avg_sequencer
// Description : Accumulates per-channel R/G/B sums and a pixel count over one
//               frame. It then runs three divisions in sequence on an external
//               divider, one per channel, and captures the 8.14 fixed-point
//               averages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_avg_sequencer #(
  parameter int unsigned MAX_PIX = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  input  logic        frame_end,
  output logic        div_start,
  output logic [21:0] intensity,
  output logic [14:0] pixel,
  output logic [1:0]  color,
  input  logic        div_complete,
  input  logic [23:0] quotient,
  output logic [21:0] avg_r,
  output logic [21:0] avg_g,
  output logic [21:0] avg_b,
  output logic        busy,
  output logic        done,
  output logic        empty,
  output logic        ovf,
  output logic        tag_err
);

  localparam logic [14:0] C_MAX_PIX = 15'(MAX_PIX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [21:0] r_sum_r;
  logic [21:0] r_sum_g;
  logic [21:0] r_sum_b;
  logic [14:0] r_count;
  logic [1:0]  r_ch;
  logic        r_div_start;
  logic [21:0] r_intensity;
  logic [14:0] r_pixel;
  logic [1:0]  r_color;
  logic [21:0] r_avg_r;
  logic [21:0] r_avg_g;
  logic [21:0] r_avg_b;
  logic        r_busy;
  logic        r_done;
  logic        r_empty;
  logic        r_ovf;
  logic        r_tag_err;

  logic        w_take;
  logic        w_ovf_hit;
  logic [21:0] w_sum_r_nx;
  logic [21:0] w_sum_g_nx;
  logic [21:0] w_sum_b_nx;
  logic [14:0] w_count_nx;
  logic [21:0] w_sum_sel;
  logic [1:0]  w_q_tag;
  logic [21:0] w_q_avg;

  // A pixel is accepted only while the count is below the cap; beyond that it
  // is dropped and flagged as overflow.
  assign w_take     = pix_valid && (r_count != C_MAX_PIX);
  assign w_ovf_hit  = pix_valid && (r_count == C_MAX_PIX);
  assign w_sum_r_nx = w_take ? (r_sum_r + 22'(pix_r)) : r_sum_r;
  assign w_sum_g_nx = w_take ? (r_sum_g + 22'(pix_g)) : r_sum_g;
  assign w_sum_b_nx = w_take ? (r_sum_b + 22'(pix_b)) : r_sum_b;
  assign w_count_nx = w_take ? (r_count + 15'd1) : r_count;
  assign w_q_tag    = quotient[23:22];
  assign w_q_avg    = quotient[21:0];

  // Pick the sum that belongs to the channel currently being divided
  always_comb begin
    w_sum_sel = r_sum_r;
    case (r_ch)
      2'd1:    w_sum_sel = r_sum_g;
      2'd2:    w_sum_sel = r_sum_b;
      default: w_sum_sel = r_sum_r;
    endcase
  end

  // Frame sequencer: accumulate, issue three divisions, capture results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sum_r     <= '0;
      r_sum_g     <= '0;
      r_sum_b     <= '0;
      r_count     <= '0;
      r_ch        <= '0;
      r_div_start <= 1'b0;
      r_intensity <= '0;
      r_pixel     <= '0;
      r_color     <= '0;
      r_avg_r     <= '0;
      r_avg_g     <= '0;
      r_avg_b     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_empty     <= 1'b0;
      r_ovf       <= 1'b0;
      r_tag_err   <= 1'b0;
    end else begin
      // Pulses default low; a state below raises them for a single cycle
      r_done      <= 1'b0;
      r_div_start <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (frame_start) begin
            r_state   <= S_ACCUM;
            r_sum_r   <= '0;
            r_sum_g   <= '0;
            r_sum_b   <= '0;
            r_count   <= '0;
            r_ch      <= '0;
            r_empty   <= 1'b0;
            r_ovf     <= 1'b0;
            r_tag_err <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (frame_start) begin
            // A new frame start discards the partial frame
            r_sum_r   <= '0;
            r_sum_g   <= '0;
            r_sum_b   <= '0;
            r_count   <= '0;
            r_ch      <= '0;
            r_empty   <= 1'b0;
            r_ovf     <= 1'b0;
            r_tag_err <= 1'b0;
          end else begin
            r_sum_r <= w_sum_r_nx;
            r_sum_g <= w_sum_g_nx;
            r_sum_b <= w_sum_b_nx;
            r_count <= w_count_nx;
            if (w_ovf_hit) begin
              r_ovf <= 1'b1;
            end
            if (frame_end) begin
              if (w_count_nx == 15'd0) begin
                // Nothing to divide: report an empty frame straight away
                r_avg_r <= '0;
                r_avg_g <= '0;
                r_avg_b <= '0;
                r_empty <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_ch    <= 2'd0;
                r_state <= S_ISSUE;
              end
            end
          end
        end
        S_ISSUE: begin
          // Operands are held here until the next issue, which keeps them
          // stable for the whole division.
          r_div_start <= 1'b1;
          r_intensity <= w_sum_sel;
          r_pixel     <= r_count;
          r_color     <= r_ch;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (div_complete) begin
            case (r_ch)
              2'd0:    r_avg_r <= w_q_avg;
              2'd1:    r_avg_g <= w_q_avg;
              default: r_avg_b <= w_q_avg;
            endcase
            if (w_q_tag != r_ch) begin
              r_tag_err <= 1'b1;
            end
            if (r_ch == 2'd2) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // Passing through ISSUE leaves one idle cycle before the next start
              r_ch    <= r_ch + 2'd1;
              r_state <= S_ISSUE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign div_start = r_div_start;
  assign intensity = r_intensity;
  assign pixel     = r_pixel;
  assign color     = r_color;
  assign avg_r     = r_avg_r;
  assign avg_g     = r_avg_g;
  assign avg_b     = r_avg_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign empty     = r_empty;
  assign ovf       = r_ovf;
  assign tag_err   = r_tag_err;

endmodule

`default_nettype wire

// File: tb/tb_channel_avg_sequencer.sv
// ============================================================================
// Module      : tb_channel_avg_sequencer
// Description : Scoreboard bench for channel_avg_sequencer. It has a
//               behavioural divider and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_channel_avg_sequencer;

  localparam int MAXP = 16384;

  typedef longint unsigned u64;

  typedef struct {
    logic [21:0] ar;
    logic [21:0] ag;
    logic [21:0] ab;
    logic        empty;
    logic        ovf;
    logic        terr;
    int          due;
  } res_t;

  typedef struct {
    logic [21:0] inten;
    logic [14:0] pix;
    logic [1:0]  col;
  } iss_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_r = '0;
  logic [7:0]  pix_g = '0;
  logic [7:0]  pix_b = '0;
  logic        frame_end = 1'b0;
  logic        div_start;
  logic [21:0] intensity;
  logic [14:0] pixel;
  logic [1:0]  color;
  logic        div_complete;
  logic [23:0] quotient;
  logic [21:0] avg_r;
  logic [21:0] avg_g;
  logic [21:0] avg_b;
  logic        busy;
  logic        done;
  logic        empty;
  logic        ovf;
  logic        tag_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Written only by the main process, read by the divider
  int div_lat = 3;
  int bad_col = -1;
  bit div_mute = 1'b0;
  bit late_req = 1'b0;

  logic [7:0] px_r[$];
  logic [7:0] px_g[$];
  logic [7:0] px_b[$];
  res_t res_q[$];
  iss_t iss_q[$];

  channel_avg_sequencer #(.MAX_PIX(MAXP)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .frame_end(frame_end),
    .div_start(div_start), .intensity(intensity), .pixel(pixel), .color(color),
    .div_complete(div_complete), .quotient(quotient),
    .avg_r(avg_r), .avg_g(avg_g), .avg_b(avg_b), .busy(busy), .done(done),
    .empty(empty), .ovf(ovf), .tag_err(tag_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: whole-frame arithmetic on the pixel list
  task automatic push_exp(input int fe, input int lat, input int bad);
    u64 s[3];
    int cnt;
    bit ov;
    res_t r;
    iss_t e;
    s = '{0, 0, 0};
    cnt = 0;
    ov = 1'b0;
    for (int i = 0; i < px_r.size(); i++) begin
      if (cnt < MAXP) begin
        s[0] += u64'(px_r[i]);
        s[1] += u64'(px_g[i]);
        s[2] += u64'(px_b[i]);
        cnt++;
      end else begin
        ov = 1'b1;
      end
    end
    r.ovf = ov;
    if (cnt == 0) begin
      r.ar = '0; r.ag = '0; r.ab = '0;
      r.empty = 1'b1;
      r.terr = 1'b0;
      r.due = fe + 1;
    end else begin
      r.ar = 22'((s[0] * 16384) / u64'(cnt));
      r.ag = 22'((s[1] * 16384) / u64'(cnt));
      r.ab = 22'((s[2] * 16384) / u64'(cnt));
      r.empty = 1'b0;
      r.terr = (bad >= 0 && bad <= 2);
      r.due = fe + 3 * (lat + 2) + 1;
      for (int c = 0; c < 3; c++) begin
        e.inten = 22'(s[c]);
        e.pix = 15'(cnt);
        e.col = 2'(c);
        iss_q.push_back(e);
      end
    end
    res_q.push_back(r);
  endtask

  // Drive one frame from px_* queues; coincide puts frame_end on the last pixel
  task automatic send_frame(input int lat, input bit coincide, input bit gaps, input int bad);
    int n;
    n = px_r.size();
    div_lat = lat;
    bad_col = bad;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("busy_accum", busy, 1);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          pix_valid = 1'b0;
          pix_r = 8'($urandom); pix_g = 8'($urandom); pix_b = 8'($urandom);
          tick();
        end
      end
      pix_valid = 1'b1;
      pix_r = px_r[i]; pix_g = px_g[i]; pix_b = px_b[i];
      if (coincide && i == n - 1) begin
        frame_end = 1'b1;
        push_exp(cyc, lat, bad);
      end
      tick();
    end
    pix_valid = 1'b0;
    if (!(coincide && n > 0)) begin
      frame_end = 1'b1;
      push_exp(cyc, lat, bad);
      tick();
    end
    frame_end = 1'b0;
  endtask

  task automatic drain;
    int k;
    k = 0;
    while ((res_q.size() != 0 || iss_q.size() != 0) && k < 500) begin
      tick();
      k++;
    end
    if (k >= 500) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending required 0", res_q.size() + iss_q.size());
      res_q.delete();
      iss_q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic load_const(input int n, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    px_r.delete(); px_g.delete(); px_b.delete();
    for (int i = 0; i < n; i++) begin
      px_r.push_back(r); px_g.push_back(g); px_b.push_back(b);
    end
  endtask

  task automatic load_rand(input int n);
    px_r.delete(); px_g.delete(); px_b.delete();
    for (int i = 0; i < n; i++) begin
      px_r.push_back(8'($urandom)); px_g.push_back(8'($urandom)); px_b.push_back(8'($urandom));
    end
  endtask

  // Behavioural divider: latency div_lat, optional bad tag, operand-hold check
  initial begin : divider
    bit late_sent;
    logic [21:0] ci;
    logic [14:0] cp;
    logic [1:0] cc;
    logic [1:0] tg;
    u64 qq;
    late_sent = 1'b0;
    div_complete = 1'b0;
    quotient = '0;
    forever begin
      @(negedge clk);
      if (late_req && !late_sent) begin
        late_sent = 1'b1;
        @(posedge clk); #1;
        div_complete = 1'b1;
        quotient = {2'd0, 22'h2AAAAA};
        @(posedge clk); #1;
        div_complete = 1'b0;
      end else if (div_start && !reset && !div_mute) begin
        ci = intensity; cp = pixel; cc = color;
        repeat (div_lat) @(posedge clk);
        #1;
        chk("hold_intensity", intensity, ci);
        chk("hold_pixel", pixel, cp);
        chk("hold_color", color, cc);
        qq = (cp != 0) ? ((u64'(ci) << 14) / u64'(cp)) : 0;
        tg = (int'(cc) == bad_col) ? 2'd3 : cc;
        div_complete = 1'b1;
        quotient = {tg, qq[21:0]};
        @(posedge clk); #1;
        div_complete = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a division or finishes
  initial begin : monitor
    res_t r;
    iss_t e;
    bit prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_done = 1'b0;
        continue;
      end
      if (prev_done) chk("done_one_cycle", done, 0);
      prev_done = done;
      if (div_start) begin
        if (iss_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_div_start: got 1 required 0 (cycle %0d)", cyc);
        end else begin
          e = iss_q.pop_front();
          chk("intensity", intensity, e.inten);
          chk("pixel", pixel, e.pix);
          chk("color", color, e.col);
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got 1 required 0 (cycle %0d)", cyc);
        end else begin
          r = res_q.pop_front();
          chk("avg_r", avg_r, r.ar);
          chk("avg_g", avg_g, r.ag);
          chk("avg_b", avg_b, r.ab);
          chk("empty", empty, r.empty);
          chk("ovf", ovf, r.ovf);
          chk("tag_err", tag_err, r.terr);
          chk("latency", cyc, r.due);
          chk("busy_done", busy, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_div_start"}, div_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_flags"}, {empty, ovf, tag_err}, 0);
    chk({tag, "_avg_r"}, avg_r, 0);
    chk({tag, "_avg_g"}, avg_g, 0);
    chk({tag, "_avg_b"}, avg_b, 0);
    chk({tag, "_intensity"}, intensity, 0);
    chk({tag, "_pixel"}, pixel, 0);
    chk({tag, "_color"}, color, 0);
  endtask

  initial begin : main
    int k;
    reset = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // Four identical pixels, known averages
    load_const(4, 8'd100, 8'd50, 8'd255);
    send_frame(3, 1'b0, 1'b0, -1);
    drain();
    chk("d_avg_r", avg_r, 22'h190000);
    chk("d_avg_g", avg_g, 22'h0C8000);
    chk("d_avg_b", avg_b, 22'h3FC000);

    // Empty frame
    load_const(0, 8'd0, 8'd0, 8'd0);
    send_frame(2, 1'b0, 1'b0, -1);
    drain();

    // One pixel coinciding with frame_end
    load_const(1, 8'd10, 8'd10, 8'd10);
    send_frame(1, 1'b1, 1'b0, -1);
    drain();

    // Divider answers green with a wrong tag
    load_rand(5);
    send_frame(4, 1'b0, 1'b1, 1);
    drain();

    // Reset while waiting on the divider, then a stale completion
    div_mute = 1'b1;
    load_rand(2);
    send_frame(3, 1'b0, 1'b0, -1);
    k = 0;
    while (iss_q.size() != 2 && k < 50) begin
      tick();
      k++;
    end
    chk("reset_test_issue_seen", (k < 50), 1);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    res_q.delete();
    iss_q.delete();
    reset = 1'b0;
    late_req = 1'b1;
    repeat (5) tick();
    chk_all_zero("late_complete");
    div_mute = 1'b0;

    // Overflow: one pixel beyond the cap, last one coincident with frame_end
    load_const(MAXP + 1, 8'd255, 8'd255, 8'd255);
    send_frame(2, 1'b1, 1'b0, -1);
    drain();

    // Randomized frames with idle-time noise on ignored inputs
    for (int f = 0; f < 30; f++) begin
      load_rand((f % 7 == 0) ? 0 : $urandom_range(1, 12));
      send_frame($urandom_range(1, 5), 1'($urandom_range(0, 1)), 1'b1,
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : -1);
      drain();
      repeat ($urandom_range(0, 3)) begin
        pix_valid = 1'($urandom);
        frame_end = 1'($urandom);
        pix_r = 8'($urandom);
        tick();
      end
      pix_valid = 1'b0;
      frame_end = 1'b0;
      repeat (2) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/channel_avg_sequencer.md
CHANNEL_AVG_SEQUENCER -- requirements
Module: channel_avg_sequencer

Interface
REQ-001 SHALL have parameter MAX_PIX, default 16384, meaning the maximum number of pixels accumulated per frame (255*16384 fits in 22 bits).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port frame_start, input, 1, one-cycle pulse that opens a new frame.
REQ-005 SHALL have port pix_valid, input, 1, qualifies pix_r/pix_g/pix_b this cycle.
REQ-006 SHALL have ports pix_r, pix_g, pix_b, input, 8 each, unsigned channel intensities.
REQ-007 SHALL have port frame_end, input, 1, one-cycle pulse that closes the frame.
REQ-008 SHALL have port div_start, output, 1, one-cycle start pulse to the divider.
REQ-009 SHALL have port intensity, output, 22, channel sum presented to the divider.
REQ-010 SHALL have port pixel, output, 15, pixel count presented to the divider.
REQ-011 SHALL have port color, output, 2, channel tag: 0=R, 1=G, 2=B.
REQ-012 SHALL have port div_complete, input, 1, one-cycle completion pulse from the divider.
REQ-013 SHALL have port quotient, input, 24, divider result: [23:22] tag, [21:0] unsigned 8.14 fixed-point average.
REQ-014 SHALL have ports avg_r, avg_g, avg_b, output, 22 each, captured averages.
REQ-015 SHALL have port busy, output, 1, high in ACCUM, ISSUE and WAIT.
REQ-016 SHALL have port done, output, 1, one-cycle pulse when all results are valid.
REQ-017 SHALL have port empty, output, 1, set when the last frame held zero pixels.
REQ-018 SHALL have port ovf, output, 1, set when the last frame exceeded MAX_PIX pixels.
REQ-019 SHALL have port tag_err, output, 1, set when quotient[23:22] differs from the issued color.

Function
REQ-020 SHALL implement the states IDLE, ACCUM, ISSUE, WAIT and DONE.
REQ-021 SHALL transition IDLE/DONE->ACCUM on frame_start, clearing sums, count, empty, ovf and tag_err; avg_* hold their previous values.
REQ-022 SHALL, in ACCUM on pix_valid with count<MAX_PIX, add each channel to its own 22-bit sum and increment a 15-bit count.
REQ-023 SHALL, on pix_valid with count==MAX_PIX, discard the pixel and set ovf; sums and count are not modified.
REQ-024 SHALL, on pix_valid and frame_end in the same cycle, include that pixel, then go ACCUM->ISSUE.
REQ-025 SHALL, at frame_end with count==0, skip division: zero avg_r/g/b, set empty, go to DONE.
REQ-026 SHALL, in ISSUE, drive div_start high for exactly one cycle with intensity=sum[ch], pixel=count and color=ch, all valid in that cycle; then go to WAIT.
REQ-027 SHALL hold intensity, pixel and color stable from div_start until div_complete.
REQ-028 SHALL, in WAIT on div_complete, capture quotient[21:0] into avg of channel ch and set tag_err if quotient[23:22]!=ch.
REQ-029 SHALL then go to ISSUE with ch+1 if ch<2, else to DONE.
REQ-030 SHALL have at least one idle cycle between div_complete and the next div_start.
REQ-031 SHALL pulse done for one cycle on the cycle DONE is entered.
REQ-032 SHALL ignore frame_start, frame_end and pix_valid in ISSUE and WAIT, and ignore frame_end and pix_valid in IDLE and DONE.
REQ-033 SHALL, on frame_start during ACCUM, restart the frame (REQ-021 behaviour).
REQ-034 SHALL ignore div_complete outside WAIT.
REQ-035 SHALL give a frame-end-to-done latency of 3*(divider latency + 2) + 1 cycles for a non-empty frame.

Reset
REQ-036 SHALL, on reset, force IDLE, zero sums, count, ch, avg_r/g/b, intensity, pixel and color, and deassert div_start, busy, done, empty, ovf and tag_err.
REQ-037 SHALL, on reset mid-division, drop the pending division; a later div_complete is ignored per REQ-034.

Verification
REQ-038 SHALL be tested: 4 pixels (100,50,255) with the divider attached -> avg_r=0x190000, avg_g=0x0C8000, avg_b=0x3FC000; done pulses once; tag_err=0.
REQ-039 SHALL be tested: frame_start then frame_end with no pixels -> no div_start, empty=1, avg_*=0, done one cycle later.
REQ-040 SHALL be tested: 16385 pixels of 255 -> ovf=1, pixel=16384, intensity=4177920, avg_r=0x3FC000.
REQ-041 SHALL be tested: stub divider returns tag 3 for color 1 -> tag_err=1, other channels unaffected.
REQ-042 SHALL be tested: reset asserted in WAIT, then a late div_complete -> module stays IDLE, all outputs 0.
REQ-043 SHALL be tested: frame_end coincident with pix_valid(10,10,10) on a 1-pixel frame -> pixel=1, intensity=10 for each channel.
